// File: rtl/alu_param_reg.sv
// -----------------------------------------------------------------------------
// alu_param_reg
//   Registered integer ALU with a 16-bit status word, used as the datapath ALU
//   of the MIPS-style core. Operands, opcode and result are sampled and
//   registered on the rising clock edge (1-cycle latency, one op per cycle).
//
// Ports:
//   clk    in   1        system clock, rising-edge active
//   rst_n  in   1        asynchronous active-low reset (clears Y and flags)
//   A      in   BITSIZE  operand A
//   B      in   BITSIZE  operand B
//   sel    in   4        opcode
//   Y      out  BITSIZE  registered result
//   flags  out  16       registered status word:
//                        bit7 N, bit6 Z, bit5 O, bit2 L, bit0 C, others 0
// -----------------------------------------------------------------------------
module alu_param_reg #(
  parameter int BITSIZE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BITSIZE-1:0] A,
  input  logic [BITSIZE-1:0] B,
  input  logic [3:0]         sel,
  output logic [BITSIZE-1:0] Y,
  output logic [15:0]        flags
);

  localparam int MSB = BITSIZE - 1;

  localparam logic [3:0] OP_XOR  = 4'b0000;
  localparam logic [3:0] OP_XNOR = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;

  // Adder carries one extra bit so the carry-out falls out of the sum.
  logic [BITSIZE:0]   add_s;
  // Subtraction is A + ~B + 1; its carry-out is not reported, so keep width.
  logic [BITSIZE-1:0] sub_s;

  logic [BITSIZE-1:0] y_s;
  logic [15:0]        flags_s;
  logic               defined_s;
  logic               o_s;
  logic               l_s;
  logic               c_s;

  assign add_s = {1'b0, A} + {1'b0, B};
  assign sub_s = A + ~B + {{(BITSIZE-1){1'b0}}, 1'b1};

  // Opcode decode: result and the op-specific flags (O, L, C).
  always_comb begin
    y_s       = '0;
    defined_s = 1'b1;
    o_s       = 1'b0;
    l_s       = 1'b0;
    c_s       = 1'b0;
    case (sel)
      OP_XOR:  y_s = A ^ B;
      OP_XNOR: y_s = ~(A ^ B);
      OP_AND:  y_s = A & B;
      OP_OR:   y_s = A | B;
      OP_NOT:  y_s = ~A;
      OP_ADD: begin
        y_s = add_s[MSB:0];
        c_s = add_s[BITSIZE];
        // Same-sign operands producing a result of the other sign.
        o_s = (A[MSB] == B[MSB]) && (add_s[MSB] != A[MSB]);
      end
      OP_SUB: begin
        y_s = sub_s;
        l_s = (A < B);
        // Opposite-sign operands where the result's sign departs from A.
        o_s = (A[MSB] != B[MSB]) && (sub_s[MSB] != A[MSB]);
      end
      default: begin
        y_s       = '0;
        defined_s = 1'b0;
      end
    endcase
  end

  // Flag word assembly; undefined opcodes report an all-zero word (Z clear).
  always_comb begin
    flags_s = 16'h0000;
    if (defined_s) begin
      flags_s = {8'h00, y_s[MSB], (y_s == '0), o_s, 1'b0, 1'b0, l_s, 1'b0, c_s};
    end else begin
      flags_s = 16'h0000;
    end
  end

  // Output registers: result and flags always from the same sampled op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y     <= '0;
      flags <= 16'h0000;
    end else begin
      Y     <= y_s;
      flags <= flags_s;
    end
  end

endmodule

// File: tb/tb_alu_param_reg.sv
module tb_alu_param_reg;

  typedef struct {
    logic [15:0] y;
    logic [15:0] f;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a16, b16, y16, f16;
  logic [3:0]  s16;
  logic [7:0]  a8, b8, y8;
  logic [15:0] f8;
  logic [3:0]  s8;

  exp_t q16[$];
  exp_t q8[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  alu_param_reg #(.BITSIZE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .sel(s16), .Y(y16), .flags(f16)
  );

  alu_param_reg #(.BITSIZE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .sel(s8), .Y(y8), .flags(f8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] ay, input logic [15:0] af,
                       input logic [15:0] ey, input logic [15:0] ef);
    chk_cnt++;
    if (ay === ey && af === ef) pass_cnt++;
    else $display("FAIL %s: got Y=%h flags=%h, expected Y=%h flags=%h", nm, ay, af, ey, ef);
  endtask

  // Behavioural reference: signed overflow from exact signed arithmetic range.
  function automatic exp_t model(input int w, input logic [3:0] s,
                                 input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint mask, half, ua, ub, sa, sb, r, ex;
    bit     def, o, l, c, n, z;
    mask = (64'sd1 <<< w) - 64'sd1;
    half = 64'sd1 <<< (w - 1);
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (ua >= half) ? ua - (64'sd1 <<< w) : ua;
    sb = (ub >= half) ? ub - (64'sd1 <<< w) : ub;
    def = 1'b1; o = 1'b0; l = 1'b0; c = 1'b0; r = 0;
    case (s)
      4'b0000: r = ua ^ ub;
      4'b0010: r = ~(ua ^ ub);
      4'b1000: r = ua & ub;
      4'b1010: r = ua | ub;
      4'b0111: r = ~ua;
      4'b0100: begin
        r  = ua + ub;
        c  = (r > mask);
        ex = sa + sb;
        o  = (ex >= half) || (ex < -half);
      end
      4'b0101: begin
        r  = ua - ub;
        l  = (ua < ub);
        ex = sa - sb;
        o  = (ex >= half) || (ex < -half);
      end
      default: def = 1'b0;
    endcase
    r = r & mask;
    if (!def) r = 0;
    n = ((r >>> (w - 1)) & 64'sd1) != 0;
    z = (r == 0);
    e.y = r[15:0];
    e.f = def ? {8'h00, n, z, o, 2'b00, l, 1'b0, c} : 16'h0000;
    e.name = "";
    return e;
  endfunction

  task automatic put16(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ey, input logic [15:0] ef, input string nm);
    exp_t e;
    @(negedge clk);
    s16 = s; a16 = a; b16 = b;
    e.y = ey; e.f = ef; e.name = nm;
    q16.push_back(e);
  endtask

  task automatic put8(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] ey, input logic [15:0] ef, input string nm);
    exp_t e;
    @(negedge clk);
    s8 = s; a8 = a; b8 = b;
    e.y = ey; e.f = ef; e.name = nm;
    q8.push_back(e);
  endtask

  // Monitor: each queued op is sampled on the next rising edge, check just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q16.size() > 0) begin
        e = q16.pop_front();
        check(e.name, y16, f16, e.y, e.f);
      end
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check(e.name, {8'h00, y8}, f8, e.y, e.f);
      end
    end
  end

  initial begin
    exp_t m;
    logic [3:0]  rs;
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    a16 = 16'h1234; b16 = 16'h5678; s16 = 4'b0100;
    a8 = 8'h12; b8 = 8'h34; s8 = 4'b0100;
    #3;
    check("reset16_async", y16, f16, 16'h0000, 16'h0000);
    check("reset8_async", {8'h00, y8}, f8, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset and logic ops
    put16(4'b0000, 16'h1234, 16'h1234, 16'h0000, 16'h0040, "xor_eq");
    put16(4'b0111, 16'h0000, 16'h5555, 16'hFFFF, 16'h0080, "not_0");
    put16(4'b0111, 16'hFFFF, 16'h0000, 16'h0000, 16'h0040, "not_ffff");
    put16(4'b1000, 16'h8001, 16'h8003, 16'h8001, 16'h0080, "and");
    put16(4'b0010, 16'h0F0F, 16'h00FF, 16'hF00F, 16'h0080, "xnor");
    put16(4'b1010, 16'h0F00, 16'h00F0, 16'h0FF0, 16'h0000, "or");
    // ADD overflow / carry / zero
    put16(4'b0100, 16'h7FFF, 16'h7FFF, 16'hFFFE, 16'h00A0, "add_pos_ovf");
    put16(4'b0100, 16'h8AD0, 16'hB1E0, 16'h3CB0, 16'h0021, "add_neg_ovf");
    put16(4'b0100, 16'hFFFF, 16'hAFFF, 16'hAFFE, 16'h0081, "add_carry");
    put16(4'b0100, 16'h0FFF, 16'h0FFF, 16'h1FFE, 16'h0000, "add_plain");
    put16(4'b0100, 16'h7530, 16'h8AD0, 16'h0000, 16'h0041, "add_zero_carry");
    // SUB
    put16(4'b0101, 16'h0064, 16'h07D0, 16'hF894, 16'h0084, "sub_less");
    put16(4'b0101, 16'h7530, 16'hB1E0, 16'hC350, 16'h00A4, "sub_ovf");
    put16(4'b0101, 16'h03E8, 16'h01F4, 16'h01F4, 16'h0000, "sub_plain");
    put16(4'b0101, 16'hFFFF, 16'h0010, 16'hFFEF, 16'h0080, "sub_neg");
    put16(4'b0101, 16'h8AD0, 16'h8AD0, 16'h0000, 16'h0040, "sub_zero");
    // Back-to-back ADD, SUB, undefined
    put16(4'b0100, 16'h0001, 16'h0002, 16'h0003, 16'h0000, "b2b_add");
    put16(4'b0101, 16'h0001, 16'h0002, 16'hFFFF, 16'h0084, "b2b_sub");
    put16(4'b1111, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "b2b_undef");
    put16(4'b0011, 16'h1234, 16'h4321, 16'h0000, 16'h0000, "undef_0011");

    // Reset asserted mid-run, away from the edge, with inputs active
    put16(4'b0111, 16'h0000, 16'h0000, 16'hFFFF, 16'h0080, "pre_reset");
    @(posedge clk);
    #3;
    s16 = 4'b0111; a16 = 16'h0000;
    rst_n = 1'b0;
    #1;
    check("reset16_mid", y16, f16, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    check("reset16_held", y16, f16, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    put16(4'b0100, 16'h0005, 16'h0006, 16'h000B, 16'h0000, "post_reset");

    // BITSIZE=8 overflow cases
    put8(4'b0100, 8'h7F, 8'h7F, 16'h00FE, 16'h00A0, "add8_pos_ovf");
    put8(4'b0100, 8'h80, 8'h80, 16'h0000, 16'h0061, "add8_neg_ovf");
    put8(4'b0101, 8'h7F, 8'h80, 16'h00FF, 16'h00A4, "sub8_ovf_less");
    put8(4'b0101, 8'h80, 8'h01, 16'h007F, 16'h0020, "sub8_ovf");
    put8(4'b0100, 8'hFF, 8'h01, 16'h0000, 16'h0041, "add8_zero_carry");

    // Random operands over every opcode, both widths, against the model
    for (int i = 0; i < 64; i++) begin
      rs = 4'($urandom_range(15, 0));
      ra = 16'($urandom);
      rb = 16'($urandom);
      m = model(16, rs, ra, rb);
      put16(rs, ra, rb, m.y, m.f, $sformatf("rand16_%0d_sel%0h", i, rs));
    end
    for (int i = 0; i < 32; i++) begin
      rs = 4'($urandom_range(15, 0));
      ra = 16'($urandom_range(255, 0));
      rb = 16'($urandom_range(255, 0));
      m = model(8, rs, ra, rb);
      put8(rs, ra[7:0], rb[7:0], m.y, m.f, $sformatf("rand8_%0d_sel%0h", i, rs));
    end

    repeat (3) @(negedge clk);
    chk_cnt++;
    if (q16.size() == 0 && q8.size() == 0) pass_cnt++;
    else $display("FAIL drain: %0d/%0d entries left, expected 0/0", q16.size(), q8.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
